maxpool2x2_stream: RTL

MAXPOOL2X2_STREAM -- requirements
Module: maxpool2x2_stream

---
 rtl/maxpool2x2_stream.sv | 105 ++++++++++
 1 files changed

// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2, stride-2 signed max pool over a row-major frame.
// Accepts one sample per cycle; the pooled result sits in a single registered valid/ready stage.
module maxpool2x2_stream #(
  parameter int DATA_WIDTH = 32,
  parameter int IMG_WIDTH  = 26,
  parameter int IMG_HEIGHT = 26
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         clear_i,
  input  logic signed [DATA_WIDTH-1:0] in_data_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  output logic signed [DATA_WIDTH-1:0] out_data_o,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic                         out_last_o,
  output logic                         frame_done_o
);

  localparam int COL_W = $clog2(IMG_WIDTH);
  localparam int ROW_W = $clog2(IMG_HEIGHT);
  localparam int BUF_N = IMG_WIDTH / 2;
  localparam int BUF_W = (BUF_N > 1) ? $clog2(BUF_N) : 1;

  if ((IMG_WIDTH < 2) || (IMG_HEIGHT < 2) || (IMG_WIDTH % 2 != 0) || (IMG_HEIGHT % 2 != 0))
  begin : g_bad_geometry
    $error("maxpool2x2_stream: IMG_WIDTH and IMG_HEIGHT must be even and at least 2");
  end

  function automatic logic signed [DATA_WIDTH-1:0] smax(
    input logic signed [DATA_WIDTH-1:0] a,
    input logic signed [DATA_WIDTH-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

  logic [COL_W-1:0]              col;
  logic [ROW_W-1:0]              row;
  logic signed [DATA_WIDTH-1:0]  hold;
  logic signed [DATA_WIDTH-1:0]  rowbuf [BUF_N];
  logic [BUF_W-1:0]              buf_idx;
  logic                          in_xfer;
  logic                          out_xfer;
  logic                          col_last;
  logic                          row_last;
  logic                          produce;
  logic signed [DATA_WIDTH-1:0]  pair_max;
  logic signed [DATA_WIDTH-1:0]  quad_max;

  assign in_ready_o = !out_valid_o || out_ready_i;
  assign in_xfer    = in_valid_i && in_ready_o;
  assign out_xfer   = out_valid_o && out_ready_i;
  assign col_last   = (col == COL_W'(IMG_WIDTH - 1));
  assign row_last   = (row == ROW_W'(IMG_HEIGHT - 1));
  assign buf_idx    = BUF_W'(col >> 1);
  assign produce    = in_xfer && row[0] && col[0];
  assign pair_max   = smax(hold, in_data_i);
  assign quad_max   = smax(pair_max, rowbuf[buf_idx]);

  // Input stage -> output register: counters, horizontal hold, pooled result
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      col          <= '0;
      row          <= '0;
      hold         <= '0;
      out_data_o   <= '0;
      out_valid_o  <= 1'b0;
      out_last_o   <= 1'b0;
      frame_done_o <= 1'b0;
    end else if (clear_i) begin
      col          <= '0;
      row          <= '0;
      out_valid_o  <= 1'b0;
      out_last_o   <= 1'b0;
      frame_done_o <= 1'b0;
    end else begin
      frame_done_o <= in_xfer && col_last && row_last;
      if (in_xfer) begin
        if (!col[0]) hold <= in_data_i;
        if (col_last) begin
          col <= '0;
          row <= row_last ? '0 : row + ROW_W'(1);
        end else begin
          col <= col + COL_W'(1);
        end
      end
      // A fresh result takes priority over draining, so valid stays high
      if (produce) begin
        out_data_o  <= quad_max;
        out_valid_o <= 1'b1;
        out_last_o  <= col_last && row_last;
      end else if (out_xfer) begin
        out_valid_o <= 1'b0;
        out_last_o  <= 1'b0;
      end
    end
  end

  // Even rows park their horizontal pair maxima for the following odd row
  always_ff @(posedge clk_i) begin
    if (in_xfer && !clear_i && !row[0] && col[0]) rowbuf[buf_idx] <= pair_max;
  end

endmodule
